// File: rtl/ase_umsg_engine.sv
// ase_umsg_engine: per-slot UMsg hint/data FSMs with write coalescing and round-robin packet output.
// Define ASE_UMSG_STATS_EN to compile in the hint/data/coalesce statistics counters.
module ase_umsg_engine #(
    parameter int NUM_UMSG   = 8,
    parameter int HINT_DELAY = 4,
    parameter int DATA_DELAY = 6,
    parameter int TIMER_W    = 8,
    parameter int DATA_W     = 512
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_UMSG-1:0] hint_en,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [5:0]          cmd_id,
    input  logic                cmd_hint,
    input  logic [DATA_W-1:0]   cmd_data,
    output logic                umsg_valid,
    input  logic                umsg_ready,
    output logic [27:0]         umsg_hdr,
    output logic [DATA_W-1:0]   umsg_data,
    output logic [NUM_UMSG-1:0] busy,
    output logic [31:0]         stat_hint_cnt,
    output logic [31:0]         stat_data_cnt,
    output logic [31:0]         stat_coal_cnt
);

    localparam int ID_W = (NUM_UMSG > 1) ? $clog2(NUM_UMSG) : 1;
    localparam logic [TIMER_W-1:0] HINT_LOAD = TIMER_W'(HINT_DELAY - 1);
    localparam logic [TIMER_W-1:0] DATA_LOAD = TIMER_W'(DATA_DELAY - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HINT_WAIT = 3'd1,
        SEND_HINT = 3'd2,
        DATA_WAIT = 3'd3,
        SEND_DATA = 3'd4
    } slot_state_e;

    slot_state_e         state     [NUM_UMSG];
    slot_state_e         state_nxt [NUM_UMSG];
    logic [TIMER_W-1:0]  timer     [NUM_UMSG];
    logic [TIMER_W-1:0]  timer_nxt [NUM_UMSG];
    logic [DATA_W-1:0]   slot_buf  [NUM_UMSG];

    logic [NUM_UMSG-1:0] cmd_hit;
    logic [NUM_UMSG-1:0] is_send;
    logic [NUM_UMSG-1:0] acc;
    logic [NUM_UMSG-1:0] gnt_vec;

    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     rr_nxt;
    logic [ID_W-1:0]     gnt_id;
    logic [ID_W-1:0]     hi_id;
    logic [ID_W-1:0]     lo_id;
    logic                hi_found;
    logic                lo_found;
    logic                gnt_found;
    logic                grant;
    logic                gnt_hint;
    logic [DATA_W-1:0]   gnt_data;

    // An out-of-range id matches no slot, so it is never ready and never accepted.
    always_comb begin
        for (int i = 0; i < NUM_UMSG; i++) begin
            cmd_hit[i] = (cmd_id == 6'(i));
            is_send[i] = (state[i] == SEND_HINT) || (state[i] == SEND_DATA);
            acc[i]     = cmd_valid && cmd_hit[i] && !is_send[i];
            busy[i]    = (state[i] != IDLE);
        end
    end

    assign cmd_ready = |(cmd_hit & ~is_send);

    // Descending scan leaves the lowest hit; hi_* keeps the lowest hit at or above the pointer.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int i = NUM_UMSG - 1; i >= 0; i--) begin
            if (is_send[i]) begin
                lo_found = 1'b1;
                lo_id    = ID_W'(i);
                if (ID_W'(i) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_id    = ID_W'(i);
                end
            end
        end
        gnt_found = hi_found || lo_found;
        gnt_id    = hi_found ? hi_id : lo_id;
        grant     = gnt_found && (!umsg_valid || umsg_ready);
        rr_nxt    = (gnt_id == ID_W'(NUM_UMSG - 1)) ? '0 : gnt_id + ID_W'(1);

        gnt_vec  = '0;
        gnt_hint = 1'b0;
        gnt_data = '0;
        for (int i = 0; i < NUM_UMSG; i++) begin
            if (gnt_id == ID_W'(i)) begin
                gnt_vec[i] = grant;
                gnt_hint   = (state[i] == SEND_HINT);
                gnt_data   = slot_buf[i];
            end
        end
    end

    // Accepts in a WAIT state only refresh the buffer; the timer keeps running.
    always_comb begin
        for (int i = 0; i < NUM_UMSG; i++) begin
            state_nxt[i] = state[i];
            timer_nxt[i] = timer[i];
            case (state[i])
                IDLE: begin
                    if (acc[i]) begin
                        if (cmd_hint && hint_en[i]) begin
                            state_nxt[i] = HINT_WAIT;
                            timer_nxt[i] = HINT_LOAD;
                        end else begin
                            state_nxt[i] = DATA_WAIT;
                            timer_nxt[i] = DATA_LOAD;
                        end
                    end
                end
                HINT_WAIT: begin
                    if (timer[i] == '0) state_nxt[i] = SEND_HINT;
                    else                timer_nxt[i] = timer[i] - TIMER_W'(1);
                end
                DATA_WAIT: begin
                    if (timer[i] == '0) state_nxt[i] = SEND_DATA;
                    else                timer_nxt[i] = timer[i] - TIMER_W'(1);
                end
                SEND_HINT: begin
                    if (gnt_vec[i]) begin
                        state_nxt[i] = DATA_WAIT;
                        timer_nxt[i] = DATA_LOAD;
                    end
                end
                SEND_DATA: begin
                    if (gnt_vec[i]) state_nxt[i] = IDLE;
                end
                default: state_nxt[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_UMSG; i++) begin
                state[i] <= IDLE;
                timer[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_UMSG; i++) begin
                state[i] <= state_nxt[i];
                timer[i] <= timer_nxt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_UMSG; i++) slot_buf[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_UMSG; i++) begin
                if (acc[i]) slot_buf[i] <= cmd_data;
            end
        end
    end

    // Single output register: refilled in the same cycle it drains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            umsg_valid <= 1'b0;
            umsg_hdr   <= '0;
            umsg_data  <= '0;
            rr_ptr     <= '0;
        end else if (grant) begin
            umsg_valid <= 1'b1;
            umsg_hdr   <= {8'h00, 4'h6, gnt_hint, 9'h000, 6'(gnt_id)};
            umsg_data  <= gnt_hint ? '0 : gnt_data;
            rr_ptr     <= rr_nxt;
        end else if (umsg_ready) begin
            umsg_valid <= 1'b0;
        end
    end

`ifdef ASE_UMSG_STATS_EN
    logic [31:0] hint_cnt;
    logic [31:0] data_cnt;
    logic [31:0] coal_cnt;
    logic        coal;

    always_comb begin
        coal = 1'b0;
        for (int i = 0; i < NUM_UMSG; i++) begin
            if (acc[i] && ((state[i] == HINT_WAIT) || (state[i] == DATA_WAIT))) coal = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hint_cnt <= '0;
            data_cnt <= '0;
            coal_cnt <= '0;
        end else begin
            if (umsg_valid && umsg_ready) begin
                if (umsg_hdr[15]) hint_cnt <= hint_cnt + 32'd1;
                else              data_cnt <= data_cnt + 32'd1;
            end
            if (coal) coal_cnt <= coal_cnt + 32'd1;
        end
    end

    assign stat_hint_cnt = hint_cnt;
    assign stat_data_cnt = data_cnt;
    assign stat_coal_cnt = coal_cnt;
`else
    assign stat_hint_cnt = '0;
    assign stat_data_cnt = '0;
    assign stat_coal_cnt = '0;
`endif

endmodule

// File: tb/tb_ase_umsg_engine.sv
// Scoreboard bench for ase_umsg_engine: timestamp-based slot model predicts packets, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_ase_umsg_engine;
    localparam int N  = 8;
    localparam int HD = 4;
    localparam int DD = 6;
    localparam int TW = 8;
    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  hint_en;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [5:0]    cmd_id;
    logic          cmd_hint;
    logic [DW-1:0] cmd_data;
    logic          umsg_valid;
    logic          umsg_ready;
    logic [27:0]   umsg_hdr;
    logic [DW-1:0] umsg_data;
    logic [N-1:0]  busy;
    logic [31:0]   stat_hint_cnt;
    logic [31:0]   stat_data_cnt;
    logic [31:0]   stat_coal_cnt;

    always #5 clk = ~clk;

    ase_umsg_engine #(
        .NUM_UMSG(N), .HINT_DELAY(HD), .DATA_DELAY(DD), .TIMER_W(TW), .DATA_W(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hint_en(hint_en),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
        .cmd_hint(cmd_hint), .cmd_data(cmd_data),
        .umsg_valid(umsg_valid), .umsg_ready(umsg_ready),
        .umsg_hdr(umsg_hdr), .umsg_data(umsg_data), .busy(busy),
        .stat_hint_cnt(stat_hint_cnt), .stat_data_cnt(stat_data_cnt),
        .stat_coal_cnt(stat_coal_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 idle, 1 hint pending, 2 data pending; due = edge at which the wait ends.
    int            m_phase [N];
    int            m_due   [N];
    logic [DW-1:0] m_buf   [N];
    bit            m_valid;
    bit            m_hint;
    int            m_rr;
    int            cyc = 0;
    bit            armed = 0;
    int unsigned   m_hcnt, m_dcnt, m_coal;
    logic [27:0]   q_hdr  [$];
    logic [DW-1:0] q_data [$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit in_send(input int s, input int e);
        return (m_phase[s] != 0) && (e > m_due[s]);
    endfunction

    function automatic bit exp_ready(input int id, input int e);
        if (id >= N) return 1'b0;
        return !in_send(id, e);
    endfunction

    task automatic model_edge();
        int  pick;
        bit  acc;
        int  id;
        cyc++;
        if (!rst_n) begin
            for (int s = 0; s < N; s++) begin
                m_phase[s] = 0; m_due[s] = 0; m_buf[s] = '0;
            end
            m_valid = 0; m_hint = 0; m_rr = 0;
            m_hcnt = 0; m_dcnt = 0; m_coal = 0;
            q_hdr.delete(); q_data.delete();
            armed = 1;
            return;
        end
        pick = -1;
        for (int k = 0; k < N; k++) begin
            if (pick < 0 && in_send((m_rr + k) % N, cyc)) pick = (m_rr + k) % N;
        end
        id  = int'(cmd_id);
        acc = cmd_valid && exp_ready(id, cyc);
        if (m_valid && umsg_ready) begin
            if (m_hint) m_hcnt++; else m_dcnt++;
            m_valid = 0;
        end
        if (pick >= 0 && (!m_valid || umsg_ready)) begin
            m_hint  = (m_phase[pick] == 1);
            m_valid = 1;
            q_hdr.push_back({8'h00, 4'h6, m_hint, 9'h000, 6'(pick)});
            q_data.push_back(m_hint ? '0 : m_buf[pick]);
            m_rr = (pick + 1) % N;
            if (m_hint) begin m_phase[pick] = 2; m_due[pick] = cyc + DD; end
            else        m_phase[pick] = 0;
        end
        if (acc) begin
            m_buf[id] = cmd_data;
            if (m_phase[id] == 0) begin
                if (cmd_hint && hint_en[id]) begin m_phase[id] = 1; m_due[id] = cyc + HD; end
                else                         begin m_phase[id] = 2; m_due[id] = cyc + DD; end
            end else begin
                m_coal++;
            end
        end
    endtask

    // Monitor: compares control state every cycle, pops the scoreboard on each handshake.
    always @(negedge clk) begin
        logic [N-1:0] mb;
        if (armed && rst_n) begin
            for (int s = 0; s < N; s++) mb[s] = (m_phase[s] != 0);
            chk("umsg_valid", umsg_valid, m_valid);
            chk("busy", busy, mb);
            chk("cmd_ready", cmd_ready, exp_ready(int'(cmd_id), cyc + 1));
            if (umsg_valid && umsg_ready) begin
                if (q_hdr.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_pkt: got hdr %0h expected no packet", umsg_hdr);
                end else begin
                    chk("pkt_hdr", umsg_hdr, q_hdr.pop_front());
                    chk("pkt_data", umsg_data, q_data.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send(input int id, input bit hint, input logic [DW-1:0] d);
        cmd_valid = 1; cmd_id = 6'(id); cmd_hint = hint; cmd_data = d;
        step();
        cmd_valid = 0;
    endtask

    task automatic drain(input int n);
        cmd_valid = 0; umsg_ready = 1;
        repeat (n) step();
    endtask

    task automatic check_stats(input string tag);
`ifdef ASE_UMSG_STATS_EN
        chk({tag, "_hint_cnt"}, stat_hint_cnt, m_hcnt);
        chk({tag, "_data_cnt"}, stat_data_cnt, m_dcnt);
        chk({tag, "_coal_cnt"}, stat_coal_cnt, m_coal);
`else
        chk({tag, "_hint_cnt"}, stat_hint_cnt, 0);
        chk({tag, "_data_cnt"}, stat_data_cnt, 0);
        chk({tag, "_coal_cnt"}, stat_coal_cnt, 0);
`endif
    endtask

    initial begin
        logic [27:0]   h0;
        logic [DW-1:0] d0, dx, rnd;
        logic [31:0]   exp_one;
        int            k;
`ifdef ASE_UMSG_STATS_EN
        exp_one = 32'd1;
`else
        exp_one = 32'd0;
`endif
        rst_n = 0; cmd_valid = 0; cmd_id = '0; cmd_hint = 0; cmd_data = '0;
        hint_en = '0; umsg_ready = 1;
        step(); step();
        rst_n = 1;
        chk("rst_valid", umsg_valid, 0);
        chk("rst_hdr", umsg_hdr, 0);
        chk("rst_data", umsg_data, 0);
        chk("rst_busy", busy, 0);
        check_stats("rst");

        // Single data packet: valid appears after edge DD+1 counted from the accept edge.
        send(3, 0, {64{8'hA5}});
        repeat (DD) step();
        chk("lat_edge6_valid", umsg_valid, 0);
        step();
        chk("lat_edge7_valid", umsg_valid, 1);
        chk("data_pkt_hdr", umsg_hdr, 28'h0060003);
        chk("data_pkt_data", umsg_data, {64{8'hA5}});
        drain(3);

        // Hint then data on slot 2.
        hint_en = 8'h04;
        dx = {16{32'hC0DE_1234}};
        send(2, 1, dx);
        k = 0;
        while (!umsg_valid && k < 30) begin step(); k++; end
        chk("hint_latency", k, HD + 1);
        chk("hint_hdr", umsg_hdr, 28'h0068002);
        chk("hint_data", umsg_data, 0);
        k = 0;
        do begin step(); k++; end while (!umsg_valid && k < 30);
        chk("hint_to_data_latency", k, DD + 1);
        chk("hint_data_hdr", umsg_hdr, 28'h0060002);
        chk("hint_data_data", umsg_data, dx);
        drain(3);
        hint_en = '0;

        // Coalesce two writes to slot 5.
        send(5, 0, DW'(32'h11));
        repeat (2) step();
        send(5, 0, DW'(32'h22));
        drain(15);
        chk("coal_stat", stat_coal_cnt, exp_one);
        check_stats("coal");

        // Pointer lands on 5 after slot 4; then 0, 4, 7 contend.
        umsg_ready = 0;
        send(4, 0, DW'(32'h44));
        repeat (8) step();
        chk("arb_first_id", umsg_hdr[5:0], 6'd4);
        send(0, 0, DW'(32'hA0));
        send(4, 0, DW'(32'hA4));
        send(7, 0, DW'(32'hA7));
        repeat (10) step();
        umsg_ready = 1;
        step(); chk("arb_order_0", umsg_hdr[5:0], 6'd7);
        step(); chk("arb_order_1", umsg_hdr[5:0], 6'd0);
        step(); chk("arb_order_2", umsg_hdr[5:0], 6'd4);
        step(); chk("arb_done_valid", umsg_valid, 0);
        drain(3);

        // Backpressure: held packet stays stable, SEND slot refuses, other slot accepts.
        umsg_ready = 0;
        send(1, 0, DW'(32'hB1));
        repeat (8) step();
        send(1, 0, DW'(32'hB2));
        repeat (8) step();
        h0 = umsg_hdr; d0 = umsg_data;
        chk("bp_held_data", d0, DW'(32'hB1));
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_valid", umsg_valid, 1);
            chk("bp_hdr_stable", umsg_hdr, h0);
            chk("bp_data_stable", umsg_data, d0);
        end
        cmd_valid = 1; cmd_id = 6'd1; #1;
        chk("bp_same_slot_ready", cmd_ready, 0);
        cmd_id = 6'd9; #1;
        chk("out_of_range_ready", cmd_ready, 0);
        cmd_id = 6'd6; cmd_data = DW'(32'hB6); #1;
        chk("bp_other_slot_ready", cmd_ready, 1);
        step();
        drain(20);
        check_stats("bp");

        // Reset with three busy slots.
        send(1, 0, DW'(32'hD1));
        send(2, 0, DW'(32'hD2));
        send(3, 0, DW'(32'hD3));
        repeat (2) step();
        chk("pre_rst_busy", busy, 8'h0E);
        rst_n = 0;
        step();
        rst_n = 1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", umsg_valid, 0);
        check_stats("mid_rst");
        drain(20);

        // Random traffic.
        for (int it = 0; it < 3000; it++) begin
            if (it % 400 == 0) hint_en = N'($urandom);
            cmd_valid  = ($urandom_range(0, 99) < 60);
            cmd_id     = 6'($urandom_range(0, 9));
            cmd_hint   = 1'($urandom);
            for (int w = 0; w < DW / 32; w++) rnd[w*32 +: 32] = $urandom;
            cmd_data   = rnd;
            umsg_ready = ($urandom_range(0, 99) < 70);
            rst_n      = ($urandom_range(0, 999) != 0);
            step();
        end
        rst_n = 1;
        drain(40);
        check_stats("rand");
        chk("rand_queue_empty", q_hdr.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
